// File: rtl/bleuart_trans_frame.sv
// UART transmit framer: small TX FIFO feeding a start/data/[parity]/stop serializer paced by tick.
// Optional parity bit generation is built in when BLEUART_TX_PARITY_EN is defined.
module bleuart_trans_frame #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          tick,
    input  logic [DATA_BITS-1:0]          in,
    input  logic                          valid,
    output logic                          rdy,
    input  logic [1:0]                    par_mode,
    output logic                          tx,
    output logic                          busy,
    output logic                          done,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam int unsigned CNT_W = 4;

`ifdef BLEUART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t                 state_q, state_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   tx_q, tx_d;
    logic                   done_q, done_d;
    logic                   busy_q, busy_d;
    logic                   rdy_q, rdy_d;
    logic [LVL_W-1:0]       level_q, level_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [DATA_BITS-1:0]   mem_q [FIFO_DEPTH];
    logic                   push_c;
    logic                   pop_c;
    logic [DATA_BITS-1:0]   head_c;

`ifdef BLEUART_TX_PARITY_EN
    logic                   par_en_q, par_en_d;
    logic                   par_bit_q, par_bit_d;
`else
    logic                   unused_par_mode;
    assign unused_par_mode = ^par_mode;
`endif

    assign push_c = valid && rdy_q;
    assign head_c = mem_q[rd_ptr_q];

    // FIFO storage; contents need no reset since level gates every read
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= in;
        end
    end

    // Frame sequencer and FIFO bookkeeping
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        cnt_d    = cnt_q;
        tx_d     = tx_q;
        done_d   = 1'b0;
        pop_c    = 1'b0;
`ifdef BLEUART_TX_PARITY_EN
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
`endif
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (level_q != '0) begin
                    pop_c   = 1'b1;
                    shift_d = head_c;
                    cnt_d   = '0;
                    state_d = START;
`ifdef BLEUART_TX_PARITY_EN
                    par_en_d  = (par_mode == 2'b01) || (par_mode == 2'b10);
                    par_bit_d = (par_mode == 2'b10) ? ~(^head_c) : (^head_c);
`endif
                end
            end
            START: begin
                if (tick) begin
                    tx_d    = 1'b0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    tx_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                    cnt_d   = CNT_W'(cnt_q + 1'b1);
                    if (cnt_q == CNT_W'(DATA_BITS - 1)) begin
                        cnt_d   = '0;
`ifdef BLEUART_TX_PARITY_EN
                        state_d = par_en_q ? PARITY : STOP;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef BLEUART_TX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    tx_d    = par_bit_q;
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    tx_d  = 1'b1;
                    cnt_d = CNT_W'(cnt_q + 1'b1);
                    if (cnt_q == CNT_W'(STOP_BITS - 1)) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        wr_ptr_d = push_c ? PTR_W'(wr_ptr_q + 1'b1) : wr_ptr_q;
        rd_ptr_d = pop_c  ? PTR_W'(rd_ptr_q + 1'b1) : rd_ptr_q;
        level_d  = level_q;
        if (push_c && !pop_c) begin
            level_d = LVL_W'(level_q + 1'b1);
        end else if (pop_c && !push_c) begin
            level_d = LVL_W'(level_q - 1'b1);
        end
        rdy_d  = (level_d < LVL_W'(FIFO_DEPTH));
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            cnt_q    <= '0;
            tx_q     <= 1'b1;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            rdy_q    <= 1'b0;
            level_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
`ifdef BLEUART_TX_PARITY_EN
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            cnt_q    <= cnt_d;
            tx_q     <= tx_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            rdy_q    <= rdy_d;
            level_q  <= level_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
`ifdef BLEUART_TX_PARITY_EN
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
`endif
        end
    end

    assign tx    = tx_q;
    assign done  = done_q;
    assign busy  = busy_q;
    assign rdy   = rdy_q;
    assign level = level_q;

endmodule

// File: tb/tb_bleuart_trans_frame.sv
// Directed bench for bleuart_trans_frame: four instances (8N1, 8N2, 5-bit, 9-bit) sharing clk/tick/rst.
module tb_bleuart_trans_frame;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic [1:0] par_mode;
    logic [8:0] din;
    logic [3:0] vld;
    logic [3:0] tx_o, rdy_o, busy_o, done_o;
    logic [2:0] lvl_o [4];

    int n_tests = 0;
    int n_fail  = 0;
    int sel     = 0;
    int done_cnt = 0;

`ifdef BLEUART_TX_PARITY_EN
    localparam int PAR_ON = 1;
`else
    localparam int PAR_ON = 0;
`endif

    always #5 clk = ~clk;

    bleuart_trans_frame #(.DATA_BITS(8), .STOP_BITS(1), .FIFO_DEPTH(4)) u_d8 (
        .clk(clk), .rst(rst), .tick(tick), .in(din[7:0]), .valid(vld[0]), .rdy(rdy_o[0]),
        .par_mode(par_mode), .tx(tx_o[0]), .busy(busy_o[0]), .done(done_o[0]), .level(lvl_o[0]));
    bleuart_trans_frame #(.DATA_BITS(8), .STOP_BITS(2), .FIFO_DEPTH(4)) u_s2 (
        .clk(clk), .rst(rst), .tick(tick), .in(din[7:0]), .valid(vld[1]), .rdy(rdy_o[1]),
        .par_mode(par_mode), .tx(tx_o[1]), .busy(busy_o[1]), .done(done_o[1]), .level(lvl_o[1]));
    bleuart_trans_frame #(.DATA_BITS(5), .STOP_BITS(1), .FIFO_DEPTH(4)) u_d5 (
        .clk(clk), .rst(rst), .tick(tick), .in(din[4:0]), .valid(vld[2]), .rdy(rdy_o[2]),
        .par_mode(par_mode), .tx(tx_o[2]), .busy(busy_o[2]), .done(done_o[2]), .level(lvl_o[2]));
    bleuart_trans_frame #(.DATA_BITS(9), .STOP_BITS(1), .FIFO_DEPTH(4)) u_d9 (
        .clk(clk), .rst(rst), .tick(tick), .in(din), .valid(vld[3]), .rdy(rdy_o[3]),
        .par_mode(par_mode), .tx(tx_o[3]), .busy(busy_o[3]), .done(done_o[3]), .level(lvl_o[3]));

    // Count done pulses of the selected instance
    always @(negedge clk) begin
        if (done_o[sel]) done_cnt <= done_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected line bits (LSB = first tick): start, data LSB first, optional parity, stops
    function automatic logic [31:0] frame(input logic [8:0] w, input int nb, input int pm,
                                          input int ns, output int len);
        logic [31:0] b;
        logic        p;
        int          k;
        b = '0;
        p = 1'b0;
        k = 1;
        for (int i = 0; i < nb; i++) begin
            b[k] = w[i];
            p    = p ^ w[i];
            k++;
        end
        if (pm == 1) begin b[k] = p;  k++; end
        if (pm == 2) begin b[k] = ~p; k++; end
        for (int i = 0; i < ns; i++) begin
            b[k] = 1'b1;
            k++;
        end
        len = k;
        return b;
    endfunction

    task automatic do_tick;
        @(negedge clk); tick = 1'b1;
        @(negedge clk); tick = 1'b0;
        @(negedge clk);
    endtask

    task automatic push(input logic [8:0] w);
        din      = w;
        vld[sel] = 1'b1;
        @(negedge clk);
        vld[sel] = 1'b0;
    endtask

    // Clock out len ticks, flipping par_mode after the first to show it has no effect mid-frame
    task automatic send_check(input string tag, input logic [31:0] exp, input int len, input int ndone);
        logic [31:0] got;
        int          d0;
        got = '0;
        d0  = done_cnt;
        for (int i = 0; i < len; i++) begin
            do_tick;
            got[i] = tx_o[sel];
            if (i == 0) par_mode = 2'b11 - par_mode;
            if (i == len - 2) check({tag, "_early_done"}, 32'(done_cnt - d0), 32'(ndone - 1));
        end
        check({tag, "_bits"}, got, exp);
        check({tag, "_done"}, 32'(done_cnt - d0), 32'(ndone));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] e;
        int          len;
        int          d0;
        logic [7:0]  fw [6];
        fw = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

        rst = 1'b0; tick = 1'b0; par_mode = 2'b00; din = '0; vld = '0;
        repeat (2) @(negedge clk);
        check("rst_tx", 32'(tx_o[0]), 1);
        check("rst_rdy", 32'(rdy_o[0]), 0);
        check("rst_busy", 32'(busy_o[0]), 0);
        check("rst_done", 32'(done_o[0]), 0);
        check("rst_level", 32'(lvl_o[0]), 0);
        rst = 1'b1;
        check("rdy_before_clk", 32'(rdy_o[0]), 0);
        @(negedge clk);
        check("rdy_after_clk", 32'(rdy_o[0]), 1);

        do_tick;
        check("idle_tick_tx", 32'(tx_o[0]), 1);
        check("idle_tick_busy", 32'(busy_o[0]), 0);

        // 8N1 0xA5: 0,1,0,1,0,0,1,0,1,1
        sel = 0; par_mode = 2'b00;
        push(9'h0A5);
        send_check("a5_none", 32'h34A, 10, 1);
        check("a5_busy_after", 32'(busy_o[0]), 0);

        if (PAR_ON == 1) begin
            par_mode = 2'b01;
            push(9'h0A5);
            send_check("a5_even", 32'h54A, 11, 1);
            par_mode = 2'b10;
            push(9'h0A5);
            send_check("a5_odd", 32'h74A, 11, 1);
        end

        // 5-bit and 9-bit words with odd parity requested
        sel = 2; par_mode = 2'b10;
        e = frame(9'h015, 5, PAR_ON * 2, 1, len);
        push(9'h015);
        send_check("d5_odd", e, len, 1);
        check("d5_len", 32'(len), (PAR_ON == 1) ? 32'd8 : 32'd7);
        sel = 3; par_mode = 2'b10;
        e = frame(9'h1C7, 9, PAR_ON * 2, 1, len);
        push(9'h1C7);
        send_check("d9_odd", e, len, 1);
        check("d9_len", 32'(len), (PAR_ON == 1) ? 32'd12 : 32'd11);

        // Two stop bits, back-to-back 0x00 then 0xFF with no idle tick between
        sel = 1; par_mode = 2'b00;
        push(9'h000);
        push(9'h0FF);
        send_check("s2_b2b", 32'h003F_F600, 22, 2);
        check("s2_level", 32'(lvl_o[1]), 0);

        // Fill the FIFO with tick held low; the sixth word must be dropped
        sel = 0; par_mode = 2'b00;
        for (int i = 0; i < 6; i++) begin
            din    = {1'b0, fw[i]};
            vld[0] = 1'b1;
            @(negedge clk);
            if (i == 3) begin
                check("fill_level3", 32'(lvl_o[0]), 3);
                check("fill_rdy3", 32'(rdy_o[0]), 1);
            end
        end
        vld[0] = 1'b0;
        check("full_level", 32'(lvl_o[0]), 4);
        check("full_rdy", 32'(rdy_o[0]), 0);
        for (int i = 0; i < 5; i++) begin
            e = frame({1'b0, fw[i]}, 8, 0, 1, len);
            send_check($sformatf("fifo_w%0d", i), e, len, 1);
        end
        check("fifo_drained_level", 32'(lvl_o[0]), 0);
        check("fifo_drained_busy", 32'(busy_o[0]), 0);

        // Reset at the 4th data tick with a second word queued
        push(9'h000);
        push(9'h055);
        repeat (4) do_tick;
        check("pre_rst_tx", 32'(tx_o[0]), 0);
        d0 = done_cnt;
        @(negedge clk);
        tick = 1'b1;
        rst  = 1'b0;
        #1;
        check("abort_tx", 32'(tx_o[0]), 1);
        check("abort_level", 32'(lvl_o[0]), 0);
        check("abort_busy", 32'(busy_o[0]), 0);
        check("abort_rdy", 32'(rdy_o[0]), 0);
        @(negedge clk); tick = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        check("abort_no_done", 32'(done_cnt - d0), 0);
        check("post_rst_rdy", 32'(rdy_o[0]), 1);
        repeat (3) do_tick;
        check("post_rst_idle", 32'(busy_o[0]), 0);
        e = frame(9'h03C, 8, 0, 1, len);
        push(9'h03C);
        send_check("post_rst_3c", e, len, 1);
        check("post_rst_level", 32'(lvl_o[0]), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
